// File: rtl/golden_checker.sv
// golden_checker: end-of-test checker that waits for a sentinel write,
// then reads back a window of data memory and compares it to a golden ROM.
module golden_checker #(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 14,
    parameter int                 NUM_CHK    = 64,
    parameter logic [ADDR_W-1:0]  END_ADDR   = 'h3fff,
    parameter logic [DATA_W-1:0]  END_CODE   = '1,
    parameter logic [ADDR_W-1:0]  TEST_START = 'h2000,
    parameter int                 MAX_CYCLE  = 100000,
    parameter int                 RD_LAT     = 1,
    localparam int                IDX_W      = $clog2(NUM_CHK + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snp_we,
    input  logic [ADDR_W-1:0] snp_addr,
    input  logic [DATA_W-1:0] snp_wdata,
    input  logic [IDX_W-1:0]  chk_num,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [IDX_W-1:0]  gold_idx,
    input  logic [DATA_W-1:0] gold_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  err_cnt,
    output logic [IDX_W-1:0]  first_err,
    output logic [63:0]       cyc_cnt
);

    typedef enum logic [2:0] {
        RUN,
        ISSUE,
        WAIT,
        CMP,
        DONE
    } state_t;

    // WAIT spans RD_LAT-1 cycles so CMP lines up with returning data
    localparam int         WAIT_N  = RD_LAT - 1;
    localparam logic [1:0] WC_LAST = 2'(WAIT_N - 1);
    localparam logic [IDX_W-1:0] N_MAX = IDX_W'(NUM_CHK);
    localparam logic [63:0] TMO_CYC = 64'(MAX_CYCLE - 1);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] n_eff;
    logic [1:0]       wcnt;

    logic             sentinel;
    logic             tmo_hit;
    logic             mismatch;
    logic             last;
    logic [IDX_W-1:0] n_clip;

    assign sentinel = snp_we && (snp_addr == END_ADDR)
                      && (snp_wdata == END_CODE);
    assign tmo_hit  = (cyc_cnt == TMO_CYC);
    // X/Z on either side is treated as a miscompare
    assign mismatch = (mem_rdata !== gold_data);
    assign last     = (IDX_W'(idx + 1'b1) == n_eff);
    assign n_clip   = (chk_num > N_MAX) ? N_MAX : chk_num;

    assign gold_idx = idx;
    assign mem_addr = TEST_START + ADDR_W'(idx);
    assign done     = (state == DONE);
    assign pass     = done && (err_cnt == '0) && !timeout;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // next-state and read request decode
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        unique case (state)
            RUN: begin
                if (sentinel || tmo_hit) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (n_eff == '0) begin
                    state_nx = DONE;
                end else begin
                    mem_req  = 1'b1;
                    state_nx = (WAIT_N == 0) ? CMP : WAIT;
                end
            end
            WAIT: begin
                if (wcnt == WC_LAST) begin
                    state_nx = CMP;
                end
            end
            CMP: begin
                state_nx = last ? DONE : ISSUE;
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    // cycle counter, check bookkeeping and error tallies
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            timeout   <= 1'b0;
            n_eff     <= '0;
            idx       <= '0;
            wcnt      <= '0;
            err_cnt   <= '0;
            first_err <= N_MAX;
        end else begin
            unique case (state)
                RUN: begin
                    cyc_cnt <= cyc_cnt + 64'd1;
                    if (sentinel || tmo_hit) begin
                        timeout <= !sentinel;
                        n_eff   <= n_clip;
                        idx     <= '0;
                    end
                end
                ISSUE: begin
                    wcnt <= '0;
                end
                WAIT: begin
                    wcnt <= wcnt + 2'd1;
                end
                CMP: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            first_err <= idx;
                        end
                    end
                    idx <= idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/golden_checker.md
GOLDEN_CHECKER -- requirements
Module: golden_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning memory word width.
REQ-002 The block SHALL have parameter ADDR_W, default 14, meaning word-address width.
REQ-003 The block SHALL have parameter NUM_CHK, default 64, meaning maximum golden entries; IDX_W = $clog2(NUM_CHK+1).
REQ-004 The block SHALL have parameter END_ADDR, default 'h3fff, meaning the sentinel word address.
REQ-005 The block SHALL have parameter END_CODE, default all-ones, meaning the sentinel value.
REQ-006 The block SHALL have parameter TEST_START, default 'h2000, meaning the first checked word address.
REQ-007 The block SHALL have parameter MAX_CYCLE, default 100000, meaning the timeout cycle count.
REQ-008 The block SHALL have parameter RD_LAT, default 1 (legal 1-4), meaning memory read latency in cycles.
REQ-009 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-010 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-011 The block SHALL have port snp_we, input, 1 bit: data-memory word write strobe being snooped.
REQ-012 The block SHALL have port snp_addr, input, ADDR_W bits: snooped write word address.
REQ-013 The block SHALL have port snp_wdata, input, DATA_W bits: snooped write data.
REQ-014 The block SHALL have port chk_num, input, IDX_W bits: number of entries to check, sampled on the RUN exit edge.
REQ-015 The block SHALL have port mem_req, output, 1 bit: one-cycle read request.
REQ-016 The block SHALL have port mem_addr, output, ADDR_W bits: read word address.
REQ-017 The block SHALL have port mem_rdata, input, DATA_W bits: read data, valid exactly RD_LAT cycles after mem_req.
REQ-018 The block SHALL have port gold_idx, output, IDX_W bits: golden ROM index.
REQ-019 The block SHALL have port gold_data, input, DATA_W bits: combinational golden ROM data for gold_idx.
REQ-020 The block SHALL have outputs done, pass, timeout (1 bit each), err_cnt (IDX_W), first_err (IDX_W) and cyc_cnt (64).

Function
REQ-021 The FSM SHALL have states RUN, ISSUE, WAIT, CMP and DONE; reset enters RUN.
REQ-022 In RUN, cyc_cnt SHALL increment by 1 every cycle; it SHALL freeze on leaving RUN.
REQ-023 RUN SHALL go to ISSUE when snp_we=1, snp_addr==END_ADDR and snp_wdata==END_CODE; that cycle is counted.
REQ-024 A write to END_ADDR with any other data, or a non-END_ADDR write, SHALL be ignored.
REQ-025 RUN SHALL go to ISSUE with timeout=1 when cyc_cnt==MAX_CYCLE-1 and no sentinel write occurs that cycle.
REQ-026 If the sentinel write and the timeout condition coincide, the sentinel SHALL win and timeout SHALL stay 0.
REQ-027 The effective count N SHALL be min(chk_num, NUM_CHK), latched on the RUN exit edge; idx SHALL be cleared to 0.
REQ-028 If N==0, ISSUE SHALL go directly to DONE.
REQ-029 In ISSUE: mem_req=1 for one cycle, mem_addr=TEST_START+idx; then go to WAIT.
REQ-030 WAIT SHALL last RD_LAT-1 cycles, so that CMP coincides with valid mem_rdata.
REQ-031 In CMP, if mem_rdata!=gold_data (bitwise, 4-state mismatch counts), err_cnt SHALL increment.
REQ-032 In CMP, on the first mismatch, first_err SHALL be set to idx.
REQ-033 After CMP, idx SHALL increment; if idx+1==N go to DONE, else go to ISSUE.
REQ-034 gold_idx SHALL equal idx at all times; mem_addr SHALL be TEST_START+idx, with mem_req=0 outside ISSUE.
REQ-035 mem_addr SHALL wrap modulo 2^ADDR_W.
REQ-036 In DONE: done=1, pass=(err_cnt==0 && !timeout); the block SHALL remain in DONE until reset, ignoring snoops.
REQ-037 first_err SHALL read NUM_CHK when there are no errors.

Reset
REQ-038 When rst_n=0 at a rising edge, the block SHALL go to RUN and clear cyc_cnt, err_cnt, idx, done, pass, timeout and mem_req, and set first_err=NUM_CHK.
REQ-039 Reset SHALL take priority over all events, including mid-CHECK, where it aborts the check with no partial done.

Verification
REQ-040 Sentinel write at cycle 500, chk_num=4, memory matches golden -> done=1, pass=1, err_cnt=0, cyc_cnt=501.
REQ-041 Same as REQ-040 but word TEST_START+2 differs -> err_cnt=1, first_err=2, pass=0.
REQ-042 No sentinel, MAX_CYCLE=100 -> timeout=1, pass=0, checking still runs, cyc_cnt=100.
REQ-043 Write of 'h0 to END_ADDR, then END_CODE 10 cycles later -> only the second write ends RUN.
REQ-044 chk_num=0 -> done the cycle after ISSUE, pass=1; chk_num=NUM_CHK+5 -> exactly NUM_CHK reads issued.
REQ-045 RD_LAT=3, with rst_n pulsed low during WAIT -> outputs return to reset values and a fresh RUN restarts cyc_cnt at 0.
